// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle for onehot_scan_decoder: the master drives the select/scan
// controls, and the slave returns the one-hot output with its status flags.
interface onehot_scan_decoder_if #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 2**SEL_W;

  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   scan_last;
  logic [DWELL_W-1:0] dwell;
  logic               wrap;
  logic               start;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               busy;
  logic               done;

  modport master (
    output en, mode, sel, scan_last, dwell, wrap, start,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  en, mode, sel, scan_last, dwell, wrap, start,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder. In scan mode it walks a single active bit
// from a captured start index to a captured last index, holding each index dwell+1 cycles.
module onehot_scan_decoder #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input logic                clk,
  input logic                rst,
  onehot_scan_decoder_if.slave bus
);
  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_idx;
  logic [SEL_W-1:0]   r_start_idx;
  logic [SEL_W-1:0]   r_last;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic [SEL_W-1:0]   w_idx_nxt;

  // Index arithmetic is naturally modulo OUT_W, so a last index below the start wraps through 0.
  assign w_idx_nxt = r_idx + 1'b1;

  function automatic logic [OUT_W-1:0] f_onehot(input logic [SEL_W-1:0] i);
    f_onehot    = '0;
    f_onehot[i] = 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_start_idx   <= '0;
      r_last        <= '0;
      r_dwell       <= '0;
      r_wrap        <= 1'b0;
      r_cnt         <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (!bus.en) begin
        r_state       <= IDLE;
        bus.out       <= '0;
        bus.out_valid <= 1'b0;
        bus.busy      <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE, DIRECT: begin
            if (!bus.mode) begin
              r_state       <= DIRECT;
              bus.out       <= f_onehot(bus.sel);
              bus.out_valid <= 1'b1;
              bus.busy      <= 1'b0;
            end else if (bus.start) begin
              r_state       <= SCAN;
              r_idx         <= bus.sel;
              r_start_idx   <= bus.sel;
              r_last        <= bus.scan_last;
              r_dwell       <= bus.dwell;
              r_wrap        <= bus.wrap;
              r_cnt         <= '0;
              bus.out       <= f_onehot(bus.sel);
              bus.out_valid <= 1'b1;
              bus.busy      <= 1'b1;
            end else begin
              r_state       <= IDLE;
              bus.out       <= '0;
              bus.out_valid <= 1'b0;
              bus.busy      <= 1'b0;
            end
          end
          SCAN: begin
            if (!bus.mode) begin
              r_state       <= DIRECT;
              bus.out       <= f_onehot(bus.sel);
              bus.out_valid <= 1'b1;
              bus.busy      <= 1'b0;
            end else if (r_cnt != r_dwell) begin
              r_cnt <= r_cnt + 1'b1;
            end else if (r_idx != r_last) begin
              r_idx   <= w_idx_nxt;
              r_cnt   <= '0;
              bus.out <= f_onehot(w_idx_nxt);
            end else if (r_wrap) begin
              r_idx   <= r_start_idx;
              r_cnt   <= '0;
              bus.out <= f_onehot(r_start_idx);
            end else begin
              r_state       <= IDLE;
              r_cnt         <= '0;
              bus.out       <= '0;
              bus.out_valid <= 1'b0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
            end
          end
          default: begin
            r_state       <= IDLE;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench: the driver pushes hand-computed expectations tagged with their edge
// number, and an independent monitor pops and compares after each rising edge.
module tb_onehot_scan_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  onehot_scan_decoder_if #(.SEL_W(4), .DWELL_W(8)) bus ();

  onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    logic [15:0] o;
    logic        b;
    logic        d;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  // Expectation for the edge that samples the inputs currently driven.
  task automatic tick(input logic [15:0] eo, input logic eb, input logic ed, input string nm);
    exp_t e;
    e.cyc = cyc + 1;
    e.o   = eo;
    e.b   = eb;
    e.d   = ed;
    e.nm  = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_scan(input logic [3:0] s, input logic [3:0] l, input logic [7:0] dw,
                          input logic wr, input logic st);
    bus.en        = 1'b1;
    bus.mode      = 1'b1;
    bus.sel       = s;
    bus.scan_last = l;
    bus.dwell     = dw;
    bus.wrap      = wr;
    bus.start     = st;
  endtask

  initial begin : monitor
    exp_t e;
    logic ev;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e  = q.pop_front();
        ev = (e.o != 16'h0);
        n_chk++;
        if (bus.out !== e.o || bus.out_valid !== ev || bus.busy !== e.b || bus.done !== e.d) begin
          n_fail++;
          $display("FAIL %s @%0d: got out=%h valid=%b busy=%b done=%b, expected out=%h valid=%b busy=%b done=%b",
                   e.nm, cyc, bus.out, bus.out_valid, bus.busy, bus.done, e.o, ev, e.b, e.d);
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] one;
    one = 16'h1;
    bus.en = 1'b1; bus.mode = 1'b0; bus.sel = 4'd5; bus.scan_last = '0;
    bus.dwell = '0; bus.wrap = 1'b0; bus.start = 1'b0;
    @(posedge clk);
    #1;

    // reset overrides en/mode/sel
    tick(16'h0, 1'b0, 1'b0, "rst_hold0");
    tick(16'h0, 1'b0, 1'b0, "rst_hold1");
    rst = 1'b0;
    tick(16'h0020, 1'b0, 1'b0, "rst_release");
    bus.en = 1'b0;
    tick(16'h0, 1'b0, 1'b0, "en_drop");

    // direct sweep
    bus.en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.sel = 4'(i);
      tick(one << i, 1'b0, 1'b0, "direct_sweep");
    end
    bus.en = 1'b0; bus.sel = 4'b1010;
    tick(16'h0, 1'b0, 1'b0, "direct_en0_a");
    tick(16'h0, 1'b0, 1'b0, "direct_en0_b");

    // scan 3..6, dwell 2, no wrap: 12 cycles then a single done
    for (int idx = 3; idx <= 6; idx++)
      for (int k = 0; k < 3; k++) begin
        set_scan(4'd3, 4'd6, 8'd2, 1'b0, (idx == 3 && k == 0));
        tick(one << idx, 1'b1, 1'b0, "scan_nowrap");
      end
    tick(16'h0, 1'b0, 1'b1, "scan_done");
    tick(16'h0, 1'b0, 1'b0, "scan_done_once");

    // captured values hold while start/sel/dwell/last are disturbed
    set_scan(4'd2, 4'd4, 8'd1, 1'b0, 1'b1);
    tick(16'h0004, 1'b1, 1'b0, "ign_2a");
    set_scan(4'd9, 4'd15, 8'd5, 1'b1, 1'b1);
    tick(16'h0004, 1'b1, 1'b0, "ign_2b");
    tick(16'h0008, 1'b1, 1'b0, "ign_3a");
    bus.start = 1'b0;
    tick(16'h0008, 1'b1, 1'b0, "ign_3b");
    tick(16'h0010, 1'b1, 1'b0, "ign_4a");
    tick(16'h0010, 1'b1, 1'b0, "ign_4b");
    tick(16'h0, 1'b0, 1'b1, "ign_done");

    // wrap-around range 14..1, dwell 0, wrap
    set_scan(4'd14, 4'd1, 8'd0, 1'b1, 1'b1);
    for (int n = 0; n < 10; n++) begin
      tick(one << ((14 + (n % 4)) % 16), 1'b1, 1'b0, "scan_wrap");
      bus.start = 1'b0;
    end
    bus.en = 1'b0;
    tick(16'h0, 1'b0, 1'b0, "abort_en");
    bus.en = 1'b1;
    tick(16'h0, 1'b0, 1'b0, "abort_en_idle");

    // mode drop aborts into direct
    set_scan(4'd5, 4'd10, 8'd3, 1'b0, 1'b1);
    tick(16'h0020, 1'b1, 1'b0, "mabort_scan0");
    bus.start = 1'b0;
    tick(16'h0020, 1'b1, 1'b0, "mabort_scan1");
    bus.mode = 1'b0; bus.sel = 4'd9;
    tick(16'h0200, 1'b0, 1'b0, "mabort_direct");
    tick(16'h0200, 1'b0, 1'b0, "mabort_direct2");

    // full range 0..15, dwell 0
    for (int i = 0; i < 16; i++) begin
      set_scan(4'd0, 4'd15, 8'd0, 1'b0, (i == 0));
      tick(one << i, 1'b1, 1'b0, "scan_full");
    end
    tick(16'h0, 1'b0, 1'b1, "scan_full_done");

    // start == last
    set_scan(4'd7, 4'd7, 8'd1, 1'b0, 1'b1);
    tick(16'h0080, 1'b1, 1'b0, "single_a");
    bus.start = 1'b0;
    tick(16'h0080, 1'b1, 1'b0, "single_b");
    tick(16'h0, 1'b0, 1'b1, "single_done");

    // synchronous reset mid-scan
    set_scan(4'd1, 4'd8, 8'd0, 1'b0, 1'b1);
    tick(16'h0002, 1'b1, 1'b0, "rscan_a");
    bus.start = 1'b0;
    tick(16'h0004, 1'b1, 1'b0, "rscan_b");
    rst = 1'b1;
    tick(16'h0, 1'b0, 1'b0, "rscan_rst");
    rst = 1'b0;
    tick(16'h0, 1'b0, 1'b0, "rscan_idle");

    repeat (3) @(posedge clk);
    #5;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
